serializer: RTL
===============

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter bus_width, default 8: parallel word width; legal values are 2 and above.
REQ-002 Parameter counter_reg, default $clog2(bus_width): bit-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  shift tick; one tick advances the serial line by one bit.
REQ-006 p_valid  input  1  a parallel word is offered on p_data.
REQ-007 p_data  input  bus_width  parallel word to transmit.
REQ-008 p_ready  output  1  the block accepts a word this cycle.
REQ-009 s_data  output  1  serial bit, MSB first.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The block SHALL use two states: IDLE and SHIFT.
REQ-013 In IDLE: p_ready=1, busy=0, s_data=0.
REQ-014 A handshake occurs when p_valid and p_ready are both 1 at a rising edge.
  - On that edge: p_data loads into the shift register, counter clears to 0, state goes to SHIFT.
REQ-015 In SHIFT: p_ready=0 and busy=1.
  - s_data SHALL equal shift register bit bus_width-1 combinationally from the register, so bit N-1 of the word is valid in the cycle right after the handshake.
REQ-016 In SHIFT, an enable edge with counter < bus_width-1 SHALL:
  - shift the register left by one, with 0 filling bit 0;
  - increment counter.
REQ-017 In SHIFT, an enable edge with counter == bus_width-1 SHALL:
  - return to IDLE;
  - assert done=1 for exactly the following cycle.
REQ-018 Each word bit SHALL be present on s_data for the cycle of its sampling enable edge.
  - A receiver shifting on the same enable edges holds the original word after bus_width ticks.
REQ-019 In SHIFT, cycles without enable SHALL hold all state; gaps between ticks of any length are legal.
REQ-020 In IDLE, enable SHALL be ignored.
REQ-021 p_valid while busy SHALL be ignored with no side effects; the source holds the word until p_ready.
REQ-022 A handshake and enable in the same IDLE cycle: the load wins and no shift occurs.
  - The first shift needs a later enable.
REQ-023 In the done cycle the block is already in IDLE.
  - p_ready=1 in that cycle, so a new handshake is accepted and back-to-back frames are allowed.
REQ-024 Counter arithmetic SHALL be unsigned, counter_reg bits wide, and never exceed bus_width-1.

Reset
REQ-025 While rst=0, regardless of clk, the block SHALL force:
  - state=IDLE, shift register=0, counter=0;
  - done=0, busy=0, s_data=0, p_ready=1.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; the first edge after release behaves as IDLE.

Structure
REQ-027 The IDLE/SHIFT state encoding SHALL live in the shared SPI package as named constants.
REQ-028 The shift register SHALL be one instance of the existing register sub-module, bus_width wide, with its enable driven by load-or-shift.
REQ-029 The counter, FSM and done flop SHALL be local to serializer.

Verification
REQ-030 Load 8'hA5, then 8 consecutive enables -> s_data = 1,0,1,0,0,1,0,1; done pulses 1 cycle after the 8th tick; p_ready returns to 1.
REQ-031 Loopback into the team's shift-in receiver on the same enable, words 8'h00, 8'hFF, 8'h3C -> receiver parallel output equals each word after 8 ticks.
REQ-032 Load 8'h81 with enables spaced 1-5 cycles randomly -> bit sequence unchanged and state held between ticks.
REQ-033 p_valid with 8'hFF while busy sending 8'h0F -> ignored; s_data = 0,0,0,0,1,1,1,1; 8'hFF is accepted only after done.
REQ-034 rst=0 after 3 ticks of 8'hC3 -> immediate busy=0, s_data=0, p_ready=1, no done; next word 8'h5A is transmitted intact.
REQ-035 p_valid held high across frames -> a new load in the done cycle; no idle gap beyond one cycle.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
// Holds the FSM state encoding used by serializer.
package serializer_pkg;

  typedef enum logic {
    st_idle  = 1'b0,
    st_shift = 1'b1
  } state_t;

  localparam int default_bus_width = 8;

endpackage : serializer_pkg

// File: rtl/serializer_reg.sv
// Generic enabled register with asynchronous active-low clear.
// Used as the serializer shift register; the caller supplies the next value.
module serializer_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // NOTE: the data register is cleared on reset as well, so the serial line
  // never shows stale word bits after an aborted frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      q <= d;
    end
  end

endmodule : serializer_reg

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: loads a word on a valid/ready handshake and
// shifts it out MSB first, one bit per enable tick, pulsing done at the end.
module serializer
  import serializer_pkg::*;
#(
  parameter int bus_width   = default_bus_width,
  parameter int counter_reg = $clog2(bus_width)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 p_valid,
  input  logic [bus_width-1:0] p_data,
  output logic                 p_ready,
  output logic                 s_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic [counter_reg-1:0] last_count = counter_reg'(bus_width - 1);

  state_t                 state;
  state_t                 state_next;
  logic [counter_reg-1:0] count;
  logic                   load;
  logic                   shift_tick;
  logic                   last_tick;
  logic [bus_width-1:0]   sr_q;
  logic [bus_width-1:0]   sr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    p_ready    = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    shift_tick = 1'b0;
    last_tick  = 1'b0;
    case (state)
      st_idle: begin
        // Enable is deliberately ignored here; a load beats a same-cycle tick.
        p_ready = 1'b1;
        if (p_valid) begin
          load       = 1'b1;
          state_next = st_shift;
        end
      end
      st_shift: begin
        busy = 1'b1;
        if (enable) begin
          if (count == last_count) begin
            last_tick  = 1'b1;
            state_next = st_idle;
          end else begin
            shift_tick = 1'b1;
          end
        end
      end
      default: state_next = st_idle;
    endcase
  end

  assign sr_d   = load ? p_data : {sr_q[bus_width-2:0], 1'b0};
  assign s_data = busy & sr_q[bus_width-1];

  serializer_reg #(
    .width(bus_width)
  ) u_shift_reg (
    .clk(clk),
    .rst(rst),
    .en (load | shift_tick),
    .d  (sr_d),
    .q  (sr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (shift_tick) begin
      count <= count + counter_reg'(1);
    end
  end

  // Done is high only in the cycle after the final tick, when already idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= last_tick;
    end
  end

endmodule : serializer
